// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for the CONV engine
package conv_pkg;

    localparam int DW   = 20;
    localparam int IN_W = 64;
    localparam int AW   = 12;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR,
        S_FIN
    } state_t;

endpackage

// File: rtl/conv_maxpool_if.sv
// rtl/conv_maxpool_if.sv - shared crd/cwr/csel memory bus between the pool stage and L0/L1 memory
interface conv_maxpool_if #(
    parameter int DW = 20,
    parameter int AW = 12
);

    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );

endinterface

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - window/sub-pixel counters and registered L0/L1 addresses for the pool stage
module pool_addr_gen #(
    parameter int IN_W = 64,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step_k,
    input  logic          step_win,
    input  logic          ld_rd,
    input  logic          ld_wr,
    output logic [1:0]    k,
    output logic          k_last,
    output logic          win_last,
    output logic          ox_wrap,
    output logic [AW-1:0] caddr_rd,
    output logic [AW-1:0] caddr_wr
);

    localparam int OW = $clog2(IN_W / 2);

    logic [OW-1:0] ox;
    logic [OW-1:0] oy;
    logic [OW-1:0] ox_nx;
    logic [OW-1:0] oy_nx;
    logic [1:0]    k_nx;
    logic [AW-1:0] rd_addr_nx;
    logic [AW-1:0] wr_addr_cur;

    assign k_last   = &k;
    assign ox_wrap  = &ox;
    assign win_last = (&ox) & (&oy);

    // Because IN_W is a power of two, the L0 address is the bit concatenation
    // row={oy,dy}, col={ox,dx}; k[1] is dy and k[0] is dx.
    assign rd_addr_nx  = AW'({oy_nx, k_nx[1], ox_nx, k_nx[0]});
    assign wr_addr_cur = AW'({oy, ox});

    // Next counter values; k wraps 3->0 on its own when the window is finished
    always_comb begin
        k_nx  = k;
        ox_nx = ox;
        oy_nx = oy;
        if (clear) begin
            k_nx  = '0;
            ox_nx = '0;
            oy_nx = '0;
        end else begin
            if (step_k) begin
                k_nx = k + 2'd1;
            end
            if (step_win) begin
                ox_nx = ox + 1'b1;
                if (ox_wrap) begin
                    oy_nx = oy + 1'b1;
                end
            end
        end
    end

    // Counter state and address registers; addresses hold while not reloaded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k        <= '0;
            ox       <= '0;
            oy       <= '0;
            caddr_rd <= '0;
            caddr_wr <= '0;
        end else begin
            k  <= k_nx;
            ox <= ox_nx;
            oy <= oy_nx;
            if (ld_rd) begin
                caddr_rd <= rd_addr_nx;
            end
            if (ld_wr) begin
                caddr_wr <= wr_addr_cur;
            end
        end
    end

endmodule

// File: rtl/conv_maxpool.sv
// rtl/conv_maxpool.sv - layer-1 2x2 stride-2 max-pool stage reading L0 memory and writing L1 memory
module conv_maxpool #(
    parameter int DW   = conv_pkg::DW,
    parameter int IN_W = conv_pkg::IN_W,
    parameter int AW   = conv_pkg::AW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    conv_maxpool_if.master bus
);

    import conv_pkg::*;

    state_t        state;
    state_t        state_nx;

    logic          clear;
    logic          step_k;
    logic          step_win;
    logic          ld_rd;
    logic          ld_wr;
    logic          cap;
    logic          cap_first;

    logic [1:0]    k;
    logic          k_last;
    logic          win_last;
    logic          ox_wrap;
    logic [AW-1:0] caddr_rd;
    logic [AW-1:0] caddr_wr;

    logic [DW-1:0] acc;
    logic [DW-1:0] pool_val;
    logic [DW-1:0] cdata_wr_q;
    logic          crd_q;
    logic          cwr_q;
    logic [2:0]    csel_q;

    pool_addr_gen #(
        .IN_W (IN_W),
        .AW   (AW)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .step_k   (step_k),
        .step_win (step_win),
        .ld_rd    (ld_rd),
        .ld_wr    (ld_wr),
        .k        (k),
        .k_last   (k_last),
        .win_last (win_last),
        .ox_wrap  (ox_wrap),
        .caddr_rd (caddr_rd),
        .caddr_wr (caddr_wr)
    );

    assign bus.crd      = crd_q;
    assign bus.cwr      = cwr_q;
    assign bus.csel     = csel_q;
    assign bus.caddr_rd = caddr_rd;
    assign bus.caddr_wr = caddr_wr;
    assign bus.cdata_wr = cdata_wr_q;

    // Read data trails its request by one cycle: RD k captures read k-1, CMP captures read 3
    assign pool_val = cap_first ? bus.cdata_rd
                    : (($signed(bus.cdata_rd) > $signed(acc)) ? bus.cdata_rd : acc);

    // Next-state and counter/capture commands
    always_comb begin
        state_nx  = state;
        clear     = 1'b0;
        step_k    = 1'b0;
        step_win  = 1'b0;
        ld_rd     = 1'b0;
        ld_wr     = 1'b0;
        cap       = 1'b0;
        cap_first = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RD;
                    clear    = 1'b1;
                    ld_rd    = 1'b1;
                end
            end
            S_RD: begin
                step_k    = 1'b1;
                cap       = (k != 2'd0);
                cap_first = (k == 2'd1);
                if (k_last) begin
                    state_nx = S_CMP;
                end else begin
                    ld_rd = 1'b1;
                end
            end
            S_CMP: begin
                cap      = 1'b1;
                ld_wr    = 1'b1;
                state_nx = S_WR;
            end
            S_WR: begin
                step_win = 1'b1;
                if (win_last) begin
                    state_nx = S_FIN;
                end else begin
                    state_nx = S_RD;
                    ld_rd    = 1'b1;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Running maximum and the write-data register loaded with the finished window maximum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            cdata_wr_q <= '0;
        end else begin
            if (cap) begin
                acc <= pool_val;
            end
            if (ld_wr) begin
                cdata_wr_q <= pool_val;
            end
        end
    end

    // Control outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            crd_q  <= 1'b0;
            cwr_q  <= 1'b0;
            csel_q <= CSEL_NONE;
        end else begin
            busy  <= (state_nx == S_RD) || (state_nx == S_CMP) || (state_nx == S_WR);
            done  <= (state_nx == S_FIN);
            crd_q <= (state_nx == S_RD);
            cwr_q <= (state_nx == S_WR);
            if ((state_nx == S_RD) || (state_nx == S_CMP)) begin
                csel_q <= CSEL_L0;
            end else if (state_nx == S_WR) begin
                csel_q <= CSEL_L1;
            end else begin
                csel_q <= CSEL_NONE;
            end
        end
    end

endmodule

// File: tb/tb_conv_maxpool.sv
// tb/tb_conv_maxpool.sv - scoreboard bench for conv_maxpool against a reference max-pool model
module tb_conv_maxpool;

    import conv_pkg::*;

    localparam int OUT_W = IN_W / 2;
    localparam int NOUT  = OUT_W * OUT_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    conv_maxpool_if #(.DW(DW), .AW(AW)) bus ();

    conv_maxpool #(
        .DW   (DW),
        .IN_W (IN_W),
        .AW   (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] l0 [IN_W*IN_W];
    logic [DW-1:0] l1 [NOUT];
    int            wr_count = 0;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    // L0/L1 memory model: registered read data, write on strobe
    always @(posedge clk) begin
        if (bus.crd) begin
            bus.cdata_rd <= l0[bus.caddr_rd];
        end
        if (bus.cwr) begin
            l1[bus.caddr_wr[$clog2(NOUT)-1:0]] <= bus.cdata_wr;
            wr_count <= wr_count + 1;
        end
    end

    // Monitor: bus protocol every cycle and scoreboard pop on every write
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (mon_on) begin
            ok = !(bus.crd && bus.cwr)
                 && (!bus.crd || bus.csel == CSEL_L0)
                 && (!bus.cwr || bus.csel == CSEL_L1)
                 && (busy || (bus.csel == CSEL_NONE && !bus.crd && !bus.cwr));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bus_protocol: crd=%0b cwr=%0b csel=%03b busy=%0b at %0t",
                         bus.crd, bus.cwr, bus.csel, busy, $time);
            end
            if (bus.cwr) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: got addr %0d data 0x%05h, expected no write",
                             bus.caddr_wr, bus.cdata_wr);
                end else begin
                    e = sb.pop_front();
                    if (32'(bus.caddr_wr) != e.addr || bus.cdata_wr !== e.data) begin
                        errors++;
                        $display("FAIL sb_write: got addr %0d data 0x%05h, expected addr %0d data 0x%05h",
                                 bus.caddr_wr, bus.cdata_wr, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pool(input int o);
        int            oy;
        int            ox;
        logic [DW-1:0] best;
        logic [DW-1:0] v;
        oy   = o / OUT_W;
        ox   = o % OUT_W;
        best = l0[(2 * oy) * IN_W + 2 * ox];
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = l0[(2 * oy + dy) * IN_W + 2 * ox + dx];
                if ($signed(v) > $signed(best)) best = v;
            end
        end
        return best;
    endfunction

    task automatic load_expected();
        exp_t e;
        sb.delete();
        for (int o = 0; o < NOUT; o++) begin
            e.addr = o;
            e.data = ref_pool(o);
            sb.push_back(e);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < IN_W * IN_W; a++) begin
            l0[a] = DW'($urandom());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     32'(busy),         0);
        check({tag, "_done"},     32'(done),         0);
        check({tag, "_crd"},      32'(bus.crd),      0);
        check({tag, "_cwr"},      32'(bus.cwr),      0);
        check({tag, "_csel"},     32'(bus.csel),     0);
        check({tag, "_caddr_rd"}, 32'(bus.caddr_rd), 0);
        check({tag, "_caddr_wr"}, 32'(bus.caddr_wr), 0);
        check({tag, "_cdata_wr"}, 32'(bus.cdata_wr), 0);
    endtask

    task automatic run_full(input bit repulse);
        int n;
        int base;
        load_expected();
        base = wr_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("busy_rise", 32'(busy), 1);
        while (!done && n < 7000) begin
            start = repulse && (n == 10 || n == 3000);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_latency", n, (NOUT * 6) + 1);
        check("busy_at_done", 32'(busy), 0);
        @(negedge clk);
        check("done_single_pulse", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("write_count", wr_count - base, NOUT);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic run_abort();
        int n;
        int base;
        load_expected();
        base = wr_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(bus.cwr && bus.caddr_wr == AW'(500)) && n < 7000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_wr500", 32'(bus.cwr && bus.caddr_wr == AW'(500)), 1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (3) @(negedge clk);
        check("abort_write_count", wr_count - base, 500);
        sb.delete();
        reset = 1'b1;
    endtask

    initial begin
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset  = 1'b1;
        mon_on = 1'b1;

        // Ramp map, with start re-pulsed mid-run
        for (int a = 0; a < IN_W * IN_W; a++) l0[a] = DW'(a);
        run_full(1'b1);
        check("ramp_l1_0",    32'(l1[0]),      32'h00041);
        check("ramp_l1_1",    32'(l1[1]),      32'h00043);
        check("ramp_l1_last", 32'(l1[NOUT-1]), 32'h00FFF);

        // Mixed-sign first window
        fill_random();
        l0[0]  = 20'hFFFFF;
        l0[1]  = 20'h00001;
        l0[64] = 20'h80000;
        l0[65] = 20'h00000;
        run_full(1'b0);
        check("signed_l1_0", 32'(l1[0]), 32'h00001);

        // All-negative first window
        fill_random();
        l0[0]  = 20'hFFFFE;
        l0[1]  = 20'hFFFFF;
        l0[64] = 20'hFFFFD;
        l0[65] = 20'h80000;
        run_full(1'b0);
        check("negative_l1_0", 32'(l1[0]), 32'h0FFFFF);

        // Reset during the write of output 500, then a clean restart
        fill_random();
        run_abort();
        run_full(1'b0);
        for (int o = 0; o < NOUT; o++) begin
            if (l1[o] !== ref_pool(o)) begin
                check("restart_l1_map", 32'(l1[o]), 32'(ref_pool(o)));
            end
        end
        check("restart_l1_last", 32'(l1[NOUT-1]), 32'(ref_pool(NOUT-1)));

        // Random maps from three seeds
        for (int s = 0; s < 3; s++) begin
            void'($urandom(32'h1000 + s));
            fill_random();
            run_full(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
